timer_ctrl: RTL and testbench

Programmable interval timer controller that sequences an internal cascade of 4-bit counting stages. It does this through a prescaler-generated clock-enable. It provides start/stop/pause/continue control, one-shot and periodic modes, and a terminal `done` pulse. It sits between control logic (buttons, a host FSM) and the counter datapath, and is the single owner of the counter's `ce` and clear.

---
 rtl/timer_ctrl.sv | 144 ++++++++++++++
 tb/tb_timer_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - programmable interval timer controller driving a cascaded 4-bit counter
//
// Purpose: sequences a prescaled clock-enable into an N_DIG x 4-bit counter,
// with start/stop/pause/continue control, one-shot and periodic modes and a
// one-cycle terminal-count pulse.
//
// Ports:
//   clk    in   1        clock, all state changes on rising edge
//   R      in   1        synchronous active-high reset
//   start  in   1        latch config, clear count, run
//   stop   in   1        abort to IDLE, clear count
//   pause  in   1        RUN -> PAUSE
//   cont   in   1        PAUSE -> RUN
//   mode   in   1        0 one-shot, 1 periodic (latched at start)
//   presc  in   PRESC_W  tick every presc+1 cycles (latched at start)
//   period in   W        terminal count (latched at start)
//   Q      out  W        current count
//   tick   out  1        counter clock-enable (combinational)
//   done   out  1        registered one-cycle terminal pulse
//   busy   out  1        RUN or PAUSE (combinational)
//   state  out  2        IDLE=0 RUN=1 PAUSE=2 DONE=3
module timer_ctrl #(
    parameter int N_DIG   = 4,
    parameter int PRESC_W = 8
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 cont,
    input  logic                 mode,
    input  logic [PRESC_W-1:0]   presc,
    input  logic [4*N_DIG-1:0]   period,
    output logic [4*N_DIG-1:0]   Q,
    output logic                 tick,
    output logic                 done,
    output logic                 busy,
    output logic [1:0]           state
);

    localparam int W = 4 * N_DIG;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_n;
    logic [W-1:0]       r_q, w_q_n;
    logic [PRESC_W-1:0] r_psc, w_psc_n;
    logic [PRESC_W-1:0] r_presc_l, w_presc_l_n;
    logic [W-1:0]       r_period_l, w_period_l_n;
    logic               r_mode_l, w_mode_l_n;
    logic               r_done, w_done_n;
    logic               w_tick;

    assign w_tick = (r_state == S_RUN) && (r_psc == r_presc_l);

    always_ff @(posedge clk) begin
        if (R) begin
            r_state    <= S_IDLE;
            r_q        <= '0;
            r_psc      <= '0;
            r_presc_l  <= '0;
            r_period_l <= '0;
            r_mode_l   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_q        <= w_q_n;
            r_psc      <= w_psc_n;
            r_presc_l  <= w_presc_l_n;
            r_period_l <= w_period_l_n;
            r_mode_l   <= w_mode_l_n;
            r_done     <= w_done_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_q_n        = r_q;
        w_psc_n      = r_psc;
        w_presc_l_n  = r_presc_l;
        w_period_l_n = r_period_l;
        w_mode_l_n   = r_mode_l;
        w_done_n     = 1'b0;

        if (stop) begin
            w_state_n = S_IDLE;
            w_q_n     = '0;
            w_psc_n   = '0;
        end else if (start) begin
            w_presc_l_n  = presc;
            w_period_l_n = period;
            w_mode_l_n   = mode;
            w_q_n        = '0;
            w_psc_n      = '0;
            w_state_n    = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    // tick is the counter's enable, so a tick in the cycle
                    // pause arrives is still honoured; pause then freezes.
                    if (pause) begin
                        w_state_n = S_PAUSE;
                    end
                    if (w_tick) begin
                        w_psc_n = '0;
                        if (r_q != r_period_l) begin
                            w_q_n = r_q + 1'b1;
                        end else begin
                            w_done_n = 1'b1;
                            if (r_mode_l) begin
                                w_q_n = '0;
                            end else begin
                                w_state_n = S_DONE;
                            end
                        end
                    end else begin
                        w_psc_n = r_psc + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (cont) begin
                        w_state_n = S_RUN;
                    end
                end
                default: begin
                    w_state_n = r_state;
                end
            endcase
        end
    end

    assign Q     = r_q;
    assign tick  = w_tick;
    assign done  = r_done;
    assign busy  = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign state = r_state;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - self-checking bench for timer_ctrl
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        R, start, stop, pause, cont, mode;
    logic [7:0]  presc;
    logic [15:0] period;
    logic [15:0] Q;
    logic        tick, done, busy;
    logic [1:0]  state;

    timer_ctrl #(.N_DIG(4), .PRESC_W(8)) dut (
        .clk(clk), .R(R), .start(start), .stop(stop), .pause(pause),
        .cont(cont), .mode(mode), .presc(presc), .period(period),
        .Q(Q), .tick(tick), .done(done), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed RUN cycles since start; count and terminal
    // derived arithmetically from the latched prescale/period.
    int     m_state;
    longint m_n, m_p, m_t, m_period;
    bit     m_mode, m_done;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint exp_q();
        if (m_state == 0) return 0;
        if (m_state == 3) return m_period;
        return (m_n / m_p) % m_t;
    endfunction

    function automatic bit exp_tick();
        return (m_state == 1) && ((m_n % m_p) == m_p - 1);
    endfunction

    task automatic model_step();
        bit tk, term;
        m_done = 0;
        if (R) begin
            m_state = 0; m_n = 0; m_p = 1; m_t = 1; m_mode = 0; m_period = 0;
        end else if (stop) begin
            m_state = 0; m_n = 0;
        end else if (start) begin
            m_p = longint'(presc) + 1; m_t = longint'(period) + 1;
            m_period = period; m_mode = mode; m_n = 0; m_state = 1;
        end else if (m_state == 1) begin
            tk   = exp_tick();
            term = tk && (((m_n + 1) % (m_p * m_t)) == 0);
            m_done = term;
            if (term && !m_mode) begin
                m_state = 3;
            end else begin
                m_n++;
                if (pause) m_state = 2;
            end
        end else if (m_state == 2 && cont) begin
            m_state = 1;
        end
    endtask

    bit last_tick;

    task automatic cyc(input bit r_i, input bit st, input bit sp, input bit pa,
                       input bit co, input bit md, input logic [7:0] ps,
                       input logic [15:0] pe);
        R = r_i; start = st; stop = sp; pause = pa; cont = co; mode = md;
        presc = ps; period = pe;
        #1;
        last_tick = tick;
        chk("tick", tick, exp_tick());
        model_step();
        @(posedge clk);
        #1;
        chk("Q", Q, exp_q());
        chk("state", state, m_state);
        chk("busy", busy, (m_state == 1 || m_state == 2));
        chk("done", done, m_done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, mode, presc, period);
    endtask

    typedef struct {
        bit          st, sp, pa, co;
        logic [15:0] q;
        logic [1:0]  s;
        bit          d;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int ticks, dones, edges;
        bit seen_f, seen_10, seen_11;

        // one-shot presc=0 period=3, then commands in DONE/IDLE
        tbl[0]  = '{1, 0, 0, 0, 16'd0, 2'd1, 0};
        tbl[1]  = '{0, 0, 0, 0, 16'd1, 2'd1, 0};
        tbl[2]  = '{0, 0, 0, 0, 16'd2, 2'd1, 0};
        tbl[3]  = '{0, 0, 0, 0, 16'd3, 2'd1, 0};
        tbl[4]  = '{0, 0, 0, 0, 16'd3, 2'd3, 1};
        tbl[5]  = '{0, 0, 0, 0, 16'd3, 2'd3, 0};
        tbl[6]  = '{0, 0, 1, 0, 16'd3, 2'd3, 0};
        tbl[7]  = '{0, 0, 0, 1, 16'd3, 2'd3, 0};
        tbl[8]  = '{0, 1, 0, 0, 16'd0, 2'd0, 0};
        tbl[9]  = '{0, 0, 1, 0, 16'd0, 2'd0, 0};
        tbl[10] = '{0, 0, 0, 1, 16'd0, 2'd0, 0};
        tbl[11] = '{1, 1, 0, 0, 16'd0, 2'd0, 0};

        R = 1; start = 0; stop = 0; pause = 0; cont = 0; mode = 0;
        presc = 0; period = 0;
        m_state = 0; m_n = 0; m_p = 1; m_t = 1; m_mode = 0; m_period = 0; m_done = 0;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_state", state, 0);
        chk("rst_q", Q, 0);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // table-driven one-shot
        for (int i = 0; i < 12; i++) begin
            cyc(0, tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].co, 0, 8'd0, 16'd3);
            chk($sformatf("tbl%0d_q", i), Q, tbl[i].q);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].s);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].d);
        end

        // one-shot: Q holds 3 for 10 cycles after completion
        cyc(0, 1, 0, 0, 0, 0, 8'd0, 16'd3);
        idle(4);
        chk("os_state", state, 3);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 8'd0, 16'd3);
            chk("os_hold_q", Q, 3);
            chk("os_no_done", done, 0);
        end

        // reset mid-run at Q=5
        cyc(0, 1, 0, 0, 0, 0, 8'd0, 16'd9);
        idle(5);
        chk("pre_rst_q", Q, 5);
        cyc(1, 0, 0, 0, 0, 0, 8'd0, 16'd9);
        cyc(1, 0, 0, 0, 0, 0, 8'd0, 16'd9);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_q", Q, 0);
        chk("mid_rst_busy", busy, 0);
        cyc(0, 0, 0, 0, 0, 0, 8'd0, 16'd9);
        chk("mid_rst_tick", tick, 0);

        // periodic presc=2 period=1 over 30 cycles
        cyc(0, 1, 0, 0, 0, 1, 8'd2, 16'd1);
        ticks = 0; dones = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 8'd7, 16'd5);
            ticks += int'(last_tick);
            dones += int'(done);
            chk("per_q_range", (Q <= 16'd1), 1);
        end
        chk("per_ticks", ticks, 10);
        chk("per_dones", dones, 5);

        // pause/cont: 7 cycles in PAUSE holding Q=4, done 17 edges after start
        cyc(0, 1, 0, 0, 0, 0, 8'd0, 16'd9);
        edges = 0;
        for (int k = 1; k <= 40 && edges == 0; k++) begin
            cyc(0, 0, 0, (k == 4), (k == 11), 0, 8'd0, 16'd9);
            if (k >= 4 && k <= 10) begin
                chk("pause_q", Q, 4);
                chk("pause_state", state, 2);
            end
            if (done) edges = k;
        end
        chk("pause_done_edge", edges, 17);

        // carry across nibble
        cyc(0, 1, 0, 0, 0, 0, 8'd0, 16'h0011);
        edges = 0; seen_f = 0; seen_10 = 0; seen_11 = 0;
        for (int k = 1; k <= 40 && edges == 0; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 8'd0, 16'h0011);
            if (Q == 16'h000F) seen_f = 1;
            if (Q == 16'h0010 && seen_f) seen_10 = 1;
            if (Q == 16'h0011 && seen_10) seen_11 = 1;
            if (done) edges = k;
        end
        chk("carry_seq", {seen_f, seen_10, seen_11}, 3'b111);
        chk("carry_done_edge", edges, 18);

        // period=0 periodic: done every cycle
        cyc(0, 1, 0, 0, 0, 1, 8'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 8'd0, 16'd0);
            chk("p0_done", done, 1);
            chk("p0_q", Q, 0);
        end

        // priority: stop beats start
        cyc(0, 1, 1, 0, 0, 0, 8'd0, 16'd5);
        chk("stop_start_state", state, 0);
        chk("stop_start_q", Q, 0);

        // start on terminal tick: restart, no done
        cyc(0, 1, 0, 0, 0, 0, 8'd0, 16'd2);
        idle(2);
        cyc(0, 1, 0, 0, 0, 0, 8'd0, 16'd2);
        chk("restart_q", Q, 0);
        chk("restart_state", state, 1);
        chk("restart_done", done, 0);

        // stop on terminal tick: no done
        idle(2);
        cyc(0, 0, 1, 0, 0, 0, 8'd0, 16'd2);
        chk("stop_term_done", done, 0);
        chk("stop_term_q", Q, 0);

        // pause in IDLE
        cyc(0, 0, 0, 1, 0, 0, 8'd0, 16'd2);
        chk("pause_idle", state, 0);

        // randomized against the model
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 150) == 0, ($urandom % 25) == 0, ($urandom % 60) == 0,
                ($urandom % 12) == 0, ($urandom % 4) == 0, 1'($urandom % 2),
                8'($urandom % 4),
                (($urandom % 10) == 0) ? 16'($urandom) : 16'($urandom % 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
